ex_stage: RTL

Execute stage of the 5-stage RV32 pipeline. Consumes the ID/EX pipeline register outputs and produces the ALU result, store data and branch/jump redirect for the EX/MEM register and fetch. Operand forwarding muxes are included, plus an iterative unsigned multiply/divide unit. The unit stalls the front of the pipeline while it runs.

---
 rtl/ex_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32 pipeline: forwarding muxes, ALU, branch/jump
// redirect, and an iterative unsigned multiply/divide unit that stalls the front end.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_dataA_EX,
    input  logic [WIDTH-1:0] i_dataB_EX,
    input  logic [WIDTH-1:0] i_pc_EX,
    input  logic [WIDTH-1:0] i_imm_ext_EX,
    input  logic             i_alu_src_EX,
    input  logic             i_branch_EX,
    input  logic             i_jump_EX,
    input  logic [2:0]       i_alu_control_EX,
    input  logic             i_md_EX,
    input  logic [1:0]       i_md_op_EX,
    input  logic [1:0]       i_forward_a_EX,
    input  logic [1:0]       i_forward_b_EX,
    input  logic [WIDTH-1:0] i_result_WB,
    input  logic [WIDTH-1:0] i_alu_result_MEM,
    output logic [WIDTH-1:0] o_alu_result_EX,
    output logic [WIDTH-1:0] o_write_data_EX,
    output logic [WIDTH-1:0] o_pc_target_EX,
    output logic             o_pc_src_EX,
    output logic             o_stall_EX,
    output logic             o_md_busy_EX
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;
    logic [1:0]       op;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] md_res;
    logic             zero;
    logic [WIDTH:0]   add_hi;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        case (i_forward_a_EX)
            2'b01:   fwd_a = i_result_WB;
            2'b10:   fwd_a = i_alu_result_MEM;
            default: fwd_a = i_dataA_EX;
        endcase
        case (i_forward_b_EX)
            2'b01:   fwd_b = i_result_WB;
            2'b10:   fwd_b = i_alu_result_MEM;
            default: fwd_b = i_dataB_EX;
        endcase
    end

    assign src_b = i_alu_src_EX ? i_imm_ext_EX : fwd_b;
    assign diff  = fwd_a - src_b;
    assign zero  = (diff == '0);

    always_comb begin
        alu_out = '0;
        case (i_alu_control_EX)
            3'b000: alu_out = fwd_a + src_b;
            3'b001: alu_out = diff;
            3'b010: alu_out = fwd_a & src_b;
            3'b011: alu_out = fwd_a | src_b;
            3'b100: alu_out = fwd_a ^ src_b;
            3'b101: alu_out = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
            3'b110: alu_out = fwd_a >> src_b[4:0];
            3'b111: alu_out = fwd_a << src_b[4:0];
            default: alu_out = '0;
        endcase
    end

    // hi/lo hold {product} for multiply and {remainder, quotient} for divide;
    // both start as {0, A} with B as multiplicand/divisor.
    assign add_hi  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    assign shifted = {hi, lo[WIDTH-1]};
    assign trial   = shifted - {1'b0, opb};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_md_EX) begin
                        hi    <= '0;
                        lo    <= fwd_a;
                        opb   <= fwd_b;
                        op    <= i_md_op_EX;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!op[1]) begin
                        {hi, lo} <= {add_hi, lo[WIDTH-1:1]};
                    end else if (!trial[WIDTH]) begin
                        hi <= trial[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi <= shifted[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (op)
            2'b00:   md_res = lo;
            2'b01:   md_res = hi;
            2'b10:   md_res = lo;
            default: md_res = hi;
        endcase
    end

    assign o_stall_EX      = ((state == IDLE) && i_md_EX) || (state == BUSY);
    assign o_md_busy_EX    = (state != IDLE);
    assign o_alu_result_EX = (state == DONE) ? md_res : alu_out;
    assign o_write_data_EX = fwd_b;
    assign o_pc_target_EX  = i_pc_EX + i_imm_ext_EX;
    assign o_pc_src_EX     = ((i_branch_EX & zero) | i_jump_EX) & ~o_stall_EX;

endmodule
